uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO. It is the next generation of the single-character send path: frame format (data width, parity, stop bits) and bit timing are set at build time. A small FIFO lets the upstream counter/button logic queue several characters, and queued frames go out back-to-back with no idle gap. It sits between the character-generating control logic and the board TX pin.

---
 rtl/uart_tx_fifo.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO.
//
// Characters are queued through a valid/ready push interface and sent as
// frames of: start bit, DATA_W data bits (LSB first), an optional parity bit,
// and STOP_BITS stop bits. Each bit lasts CLK_DIV clock cycles. When words are
// queued, frames go out back-to-back with no idle cycle between them.
//
// Ports:
//   i_clk    in   1                       single clock, rising edge
//   i_rst_n  in   1                       synchronous active-low reset
//   i_data   in   DATA_W                  character to queue
//   i_valid  in   1                       i_data valid this cycle
//   o_ready  out  1                       FIFO not full (depends on count only)
//   o_txd    out  1                       registered serial line, idles high
//   o_busy   out  1                       a frame is in progress
//   o_level  out  $clog2(FIFO_DEPTH+1)    words queued, excluding the one in flight
module uart_tx_fifo #(
  parameter int CLK_DIV    = 5,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [DATA_W-1:0]                 i_data,
  input  logic                              i_valid,
  output logic                              o_ready,
  output logic                              o_txd,
  output logic                              o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  // Build-time sanity checks on the frame and FIFO parameters.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_fifo: CLK_DIV must be at least 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_fifo: DATA_W must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic              head_par;

  // The count register alone decides full/empty; pointers simply wrap.
  assign full    = (count == LVL_FULL);
  assign empty   = (count == '0);
  assign o_ready = !full;
  assign o_level = count;

  // A push while full is dropped even if a pop happens on the same edge,
  // because ready is taken from the registered count.
  assign push = i_valid && !full;

  assign head = mem[rd_ptr];
  // Odd parity makes the total number of ones (data + parity) odd.
  assign head_par = (PARITY == 1) ? ~^head : ^head;

  // NOTE: the storage array has no reset; validity is tracked by count and
  // the pointers, so resetting the words themselves would only cost logic.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter FSM
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // cycle within the current bit
  logic [IDX_W-1:0]  idx_q, idx_d;      // data-bit index, reused for stop bits
  logic [DATA_W-1:0] shift_q, shift_d;  // remaining data bits, LSB goes out next
  logic              par_q, par_d;      // parity of the word in flight
  logic              txd_q, txd_d;
  logic              tick;              // last cycle of the current bit period

  assign tick = (cnt_q == CNT_LAST);

  // NOTE: every variable driven here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;

    // The bit counter runs in every non-idle state and wraps at each bit
    // boundary, which is also where every state change happens, so it is
    // always 0 on state entry.
    if (state_q != ST_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        pop = !empty;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (idx_q == STOP_LAST) begin
            // Chain straight into the next start bit when a word is waiting.
            pop     = !empty;
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop) begin
      shift_d = head;
      par_d   = head_par;
      state_d = ST_START;
      cnt_d   = '0;
      idx_d   = '0;
    end

    // The line level is computed from the next state so o_txd can be a
    // plain register aligned with the state change.
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      ST_PAR:   txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign o_txd  = txd_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
//
// Four instances share clock and reset:
//   u0: 8 data bits, no parity, 1 stop
//   u1: 8 data bits, even parity, 1 stop
//   u2: 8 data bits, odd parity, 1 stop
//   u3: 5 data bits, no parity, 2 stop
// A reference model built from queued words and whole-frame bit vectors
// predicts every output of every instance on every cycle.
module tb_uart_tx_fifo;

  localparam int NI    = 4;
  localparam int DIV   = 5;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid [NI];
  logic [8:0] data  [NI];
  logic       txd   [NI];
  logic       busy  [NI];
  logic       ready [NI];
  logic [2:0] level [NI];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[0][7:0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_txd(txd[0]), .o_busy(busy[0]), .o_level(level[0]));

  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[1][7:0]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_txd(txd[1]), .o_busy(busy[1]), .o_level(level[1]));

  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[2][7:0]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_txd(txd[2]), .o_busy(busy[2]), .o_level(level[2]));

  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_W(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[3][4:0]), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_txd(txd[3]), .o_busy(busy[3]), .o_level(level[3]));

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h expected=%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int cfg_dw(input int i);
    return (i == 3) ? 5 : 8;
  endfunction

  function automatic int cfg_par(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction

  function automatic int cfg_stop(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  // Whole frame as a bit vector, bit 0 transmitted first.
  function automatic logic [15:0] build_frame(input int i, input logic [8:0] d, output int nb);
    logic [15:0] f;
    int          ones;
    f    = '1;
    nb   = 0;
    ones = 0;
    f[nb] = 1'b0;
    nb++;
    for (int k = 0; k < cfg_dw(i); k++) begin
      f[nb] = d[k];
      ones += int'(d[k]);
      nb++;
    end
    if (cfg_par(i) == 1) begin
      f[nb] = ((ones % 2) == 0);
      nb++;
    end else if (cfg_par(i) == 2) begin
      f[nb] = ((ones % 2) == 1);
      nb++;
    end
    for (int s = 0; s < cfg_stop(i); s++) begin
      f[nb] = 1'b1;
      nb++;
    end
    return f;
  endfunction

  int          m_n    [NI];
  int          m_head [NI];
  int          m_bit  [NI];
  int          m_cyc  [NI];
  int          m_nb   [NI];
  bit          m_act  [NI];
  logic [8:0]  m_mem  [NI][DEPTH];
  logic [15:0] m_fb   [NI];

  task automatic model_update();
    bit full_pre;
    bit any_pre;
    int wi;
    int nb;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_n[i]    = 0;
        m_head[i] = 0;
        m_bit[i]  = 0;
        m_cyc[i]  = 0;
        m_act[i]  = 1'b0;
      end else begin
        full_pre = (m_n[i] == DEPTH);
        any_pre  = (m_n[i] > 0);
        if (m_act[i]) begin
          m_cyc[i]++;
          if (m_cyc[i] == DIV) begin
            m_cyc[i] = 0;
            m_bit[i]++;
            if (m_bit[i] == m_nb[i]) m_act[i] = 1'b0;
          end
        end
        if (!m_act[i] && any_pre) begin
          m_fb[i]   = build_frame(i, m_mem[i][m_head[i]], nb);
          m_nb[i]   = nb;
          m_head[i] = (m_head[i] + 1) % DEPTH;
          m_n[i]--;
          m_act[i]  = 1'b1;
          m_bit[i]  = 0;
          m_cyc[i]  = 0;
        end
        if (valid[i] && !full_pre) begin
          wi = (m_head[i] + m_n[i]) % DEPTH;
          m_mem[i][wi] = data[i];
          m_n[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check("txd",   i, 32'(txd[i]),   m_act[i] ? 32'(m_fb[i][m_bit[i]]) : 32'd1);
      check("busy",  i, 32'(busy[i]),  32'(m_act[i]));
      check("level", i, 32'(level[i]), 32'(m_n[i]));
      check("ready", i, 32'(ready[i]), (m_n[i] < DEPTH) ? 32'd1 : 32'd0);
    end
  endtask

  // One clock: inputs set by the caller are sampled at the edge, the model
  // advances, and outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  // ---------------------------------------------------------------------------
  // Directed single-frame vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int          inst;
    logic [8:0]  data;
    logic [15:0] bits;    // expected frame, bit 0 sent first
    int          cycles;  // expected frame length in clocks
  } vec_t;

  vec_t       vecs [6];
  logic [8:0] w    [6];
  int         sent;
  int         accept_edge;
  int         lows;
  bit         acc;

  initial begin
    vecs[0] = '{inst: 0, data: 9'h00A, bits: 16'h0214, cycles: 50};  // 0,0,1,0,1,0,0,0,0,1
    vecs[1] = '{inst: 1, data: 9'h007, bits: 16'h060E, cycles: 55};  // even parity bit 1
    vecs[2] = '{inst: 2, data: 9'h007, bits: 16'h040E, cycles: 55};  // odd parity bit 0
    vecs[3] = '{inst: 3, data: 9'h015, bits: 16'h00EA, cycles: 40};  // 0,1,0,1,0,1,1,1
    vecs[4] = '{inst: 0, data: 9'h0FF, bits: 16'h03FE, cycles: 50};
    vecs[5] = '{inst: 3, data: 9'h000, bits: 16'h00C0, cycles: 40};

    // Reset held 3 cycles with valid high: nothing may be queued.
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b1;
      data[i]  = 9'h1A5;
    end
    repeat (3) begin
      step();
      for (int i = 0; i < NI; i++) begin
        check("rst_txd",   i, 32'(txd[i]),   32'd1);
        check("rst_ready", i, 32'(ready[i]), 32'd1);
        check("rst_busy",  i, 32'(busy[i]),  32'd0);
        check("rst_level", i, 32'(level[i]), 32'd0);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) valid[i] = 1'b0;
    repeat (3) begin
      step();
      for (int i = 0; i < NI; i++) begin
        check("rst_nothing_queued", i, 32'(level[i]), 32'd0);
        check("rst_idle_txd",       i, 32'(txd[i]),   32'd1);
      end
    end

    // Table-driven single frames into an empty, idle block.
    for (int v = 0; v < 6; v++) begin
      valid[vecs[v].inst] = 1'b1;
      data[vecs[v].inst]  = vecs[v].data;
      step();
      valid[vecs[v].inst] = 1'b0;
      check("push_edge_txd",   vecs[v].inst, 32'(txd[vecs[v].inst]),   32'd1);
      check("push_edge_level", vecs[v].inst, 32'(level[vecs[v].inst]), 32'd1);
      for (int j = 0; j < vecs[v].cycles; j++) begin
        step();
        check("frame_bit", vecs[v].inst, 32'(txd[vecs[v].inst]), 32'(vecs[v].bits[j / DIV]));
        if (j == 0) check("start_busy", vecs[v].inst, 32'(busy[vecs[v].inst]), 32'd1);
      end
      step();
      check("end_busy", vecs[v].inst, 32'(busy[vecs[v].inst]), 32'd0);
      check("end_txd",  vecs[v].inst, 32'(txd[vecs[v].inst]),  32'd1);
    end

    // Burst of 6 words with valid held: FIFO fills, word 5 stalls until the
    // first frame boundary pop at edge 51, and is accepted at edge 52.
    for (int k = 0; k < 6; k++) w[k] = 9'($urandom_range(0, 255));
    sent        = 0;
    accept_edge = -1;
    for (int e = 0; e < 60; e++) begin
      valid[0] = (sent < 6);
      data[0]  = w[(sent < 6) ? sent : 5];
      acc      = valid[0] && ready[0];
      step();
      if (acc) begin
        sent++;
        if (sent == 6) accept_edge = e;
      end
      if (e == 4) begin
        check("burst_level_full", 0, 32'(level[0]), 32'd4);
        check("burst_ready_low",  0, 32'(ready[0]), 32'd0);
      end
    end
    valid[0] = 1'b0;
    check("burst_word5_edge", 0, 32'(accept_edge), 32'd52);
    repeat (6 * 50) step();
    check("burst_drained_busy",  0, 32'(busy[0]),  32'd0);
    check("burst_drained_level", 0, 32'(level[0]), 32'd0);

    // Reset during bit 3 of the first frame of a 3-word burst.
    for (int e = 0; e < 3; e++) begin
      valid[0] = 1'b1;
      data[0]  = 9'($urandom_range(0, 255));
      step();
    end
    valid[0] = 1'b0;
    for (int e = 3; e < 18; e++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_txd",   0, 32'(txd[0]),   32'd1);
    check("midrst_level", 0, 32'(level[0]), 32'd0);
    check("midrst_busy",  0, 32'(busy[0]),  32'd0);
    lows = 0;
    repeat (150) begin
      step();
      if (txd[0] !== 1'b1) lows++;
    end
    check("midrst_no_more_frames", 0, 32'(lows), 32'd0);

    // Randomized traffic, alternating sparse and dense phases, rare resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < NI; i++) begin
        valid[i] = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 40 : 3));
        data[i]  = 9'($urandom_range(0, 511));
      end
      step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) valid[i] = 1'b0;
    repeat (300) step();
    for (int i = 0; i < NI; i++) begin
      check("final_idle_busy",  i, 32'(busy[i]),  32'd0);
      check("final_idle_level", i, 32'(level[i]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
